// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch counting core.
package stopwatch_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        UP    = 3'd1,
        DOWN  = 3'd2,
        PAUSE = 3'd3,
        ADD   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        OP_INC = 2'd0,
        OP_DEC = 2'd1,
        OP_ADD = 2'd2
    } op_t;

    localparam logic [1:0] MODE_UP   = 2'b10;
    localparam logic [1:0] MODE_DOWN = 2'b00;
    localparam logic [1:0] MODE_HOLD = 2'b11;
    localparam logic [1:0] MODE_IDLE = 2'b01;

    function automatic logic [1:0] mode_of(input state_t st);
        case (st)
            UP:      mode_of = MODE_UP;
            DOWN:    mode_of = MODE_DOWN;
            IDLE:    mode_of = MODE_IDLE;
            default: mode_of = MODE_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/stopwatch_step.sv
// Combinational count stepper: +1, -1 or +ADD_STEP with wrap/saturate at 0..MAX_VAL.
module stopwatch_step
    import stopwatch_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 99,
    parameter int ADD_STEP = 5,
    parameter int WRAP     = 1
) (
    input  logic [WIDTH-1:0] count,
    input  op_t              op,
    output logic [WIDTH-1:0] next_count,
    output logic             bound_hit
);

    localparam logic [WIDTH:0] MAXW  = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH:0] STEPW = (WIDTH+1)'(ADD_STEP);

    logic [WIDTH:0] cnt_w;
    logic [WIDTH:0] sum;

    // Next count and bound detection for the requested operation
    always_comb begin
        cnt_w      = {1'b0, count};
        sum        = cnt_w + STEPW;
        next_count = count;
        bound_hit  = 1'b0;
        case (op)
            OP_INC: begin
                if (cnt_w == MAXW) begin
                    bound_hit  = 1'b1;
                    next_count = (WRAP != 0) ? '0 : WIDTH'(MAXW);
                end else begin
                    next_count = WIDTH'(cnt_w + 1'b1);
                end
            end
            OP_DEC: begin
                if (cnt_w == '0) begin
                    bound_hit  = 1'b1;
                    next_count = (WRAP != 0) ? WIDTH'(MAXW) : '0;
                end else begin
                    next_count = WIDTH'(cnt_w - 1'b1);
                end
            end
            OP_ADD: begin
                if (sum > MAXW) begin
                    bound_hit  = 1'b1;
                    next_count = (WRAP != 0) ? WIDTH'(sum - (MAXW + 1'b1)) : WIDTH'(MAXW);
                end else begin
                    next_count = WIDTH'(sum);
                end
            end
            default: begin
                next_count = count;
                bound_hit  = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/stopwatch_counter_p.sv
// Parametrised stopwatch core: up/down counting, pause, preset load,
// one-shot add and wrap/saturate at 0..MAX_VAL. All outputs registered.
module stopwatch_counter_p
    import stopwatch_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int MAX_VAL  = 99,
    parameter int ADD_STEP = 5,
    parameter int WRAP     = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             tick_en,
    input  logic             run,
    input  logic             dir_up,
    input  logic             add_req,
    input  logic             clr,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       mode,
    output logic             tc,
    output logic             running
);

    localparam logic [WIDTH-1:0] MAXC = WIDTH'(MAX_VAL);
    localparam bit               SAT  = (WRAP == 0);

    state_t           state, state_n;
    logic [WIDTH-1:0] count_n;
    logic             tc_n;
    // Set by a saturating auto-pause; blocks restart until run has been low.
    logic             lock, lock_n;
    op_t              op;
    logic [WIDTH-1:0] step_count;
    logic             step_bound;
    state_t           dir_st;
    logic             in_run;

    stopwatch_step #(
        .WIDTH    (WIDTH),
        .MAX_VAL  (MAX_VAL),
        .ADD_STEP (ADD_STEP),
        .WRAP     (WRAP)
    ) u_step (
        .count      (count),
        .op         (op),
        .next_count (step_count),
        .bound_hit  (step_bound)
    );

    // Next-state, next-count and terminal-count decision in priority order
    always_comb begin
        state_n = state;
        count_n = count;
        tc_n    = 1'b0;
        lock_n  = lock & run;
        dir_st  = dir_up ? UP : DOWN;
        in_run  = (state == UP) || (state == DOWN);
        case (state)
            UP:      op = OP_INC;
            DOWN:    op = OP_DEC;
            ADD:     op = OP_ADD;
            default: op = OP_INC;
        endcase

        if (clr) begin
            state_n = IDLE;
            count_n = '0;
            lock_n  = 1'b0;
        end else if (load_en && (state == IDLE || state == PAUSE)) begin
            count_n = (load_val > MAXC) ? MAXC : load_val;
            state_n = PAUSE;
        end else if (add_req && state != ADD) begin
            state_n = ADD;
            // A tick arriving alongside the add request is still honoured.
            if (in_run && tick_en) begin
                count_n = step_count;
                tc_n    = step_bound;
                if (step_bound && SAT)
                    lock_n = 1'b1;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (run)
                        state_n = dir_st;
                end
                UP, DOWN: begin
                    if (tick_en) begin
                        count_n = step_count;
                        tc_n    = step_bound;
                    end
                    if (tick_en && step_bound && SAT) begin
                        state_n = PAUSE;
                        lock_n  = 1'b1;
                    end else if (!run) begin
                        state_n = PAUSE;
                    end else begin
                        state_n = dir_st;
                    end
                end
                PAUSE: begin
                    if (run && !lock)
                        state_n = dir_st;
                end
                ADD: begin
                    count_n = step_count;
                    tc_n    = step_bound;
                    state_n = (run && !lock) ? dir_st : PAUSE;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // State, count and registered output decode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            count   <= '0;
            tc      <= 1'b0;
            lock    <= 1'b0;
            mode    <= MODE_IDLE;
            running <= 1'b0;
        end else begin
            state   <= state_n;
            count   <= count_n;
            tc      <= tc_n;
            lock    <= lock_n;
            mode    <= mode_of(state_n);
            running <= (state_n == UP) || (state_n == DOWN);
        end
    end

endmodule

// File: tb/tb_stopwatch_counter_p.sv
// Directed self-checking bench: one wrapping and one saturating instance
// driven by shared stimulus.
module tb_stopwatch_counter_p;

    logic       clk = 1'b0;
    logic       rstn;
    logic       tick_en, run, dir_up, add_req, clr, load_en;
    logic [6:0] load_val;

    logic [6:0] count_w, count_s;
    logic [1:0] mode_w, mode_s;
    logic       tc_w, tc_s, running_w, running_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stopwatch_counter_p #(
        .WIDTH(7), .MAX_VAL(99), .ADD_STEP(5), .WRAP(1)
    ) dut_w (
        .clk(clk), .rstn(rstn), .tick_en(tick_en), .run(run), .dir_up(dir_up),
        .add_req(add_req), .clr(clr), .load_en(load_en), .load_val(load_val),
        .count(count_w), .mode(mode_w), .tc(tc_w), .running(running_w)
    );

    stopwatch_counter_p #(
        .WIDTH(7), .MAX_VAL(99), .ADD_STEP(5), .WRAP(0)
    ) dut_s (
        .clk(clk), .rstn(rstn), .tick_en(tick_en), .run(run), .dir_up(dir_up),
        .add_req(add_req), .clr(clr), .load_en(load_en), .load_val(load_val),
        .count(count_s), .mode(mode_s), .tc(tc_s), .running(running_s)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        tick_en = 0; run = 0; dir_up = 0; add_req = 0;
        clr = 0; load_en = 0; load_val = '0;
    endtask

    initial begin
        idle_inputs();
        rstn = 0;
        #12;
        chk("rst_count", count_w, 0);
        chk("rst_mode", mode_w, 1);
        chk("rst_tc", tc_w, 0);
        chk("rst_running", running_w, 0);
        chk("rst_mode_s", mode_s, 1);
        rstn = 1;
        cyc();

        // Basic up count, 5 ticks
        run = 1; dir_up = 1;
        cyc();
        chk("up_start_mode", mode_w, 2);
        chk("up_start_count", count_w, 0);
        tick_en = 1;
        for (int i = 1; i <= 5; i++) begin
            cyc();
            chk("up_count", count_w, i);
            chk("up_tc", tc_w, 0);
        end
        chk("up_running", running_w, 1);
        chk("up_mode", mode_w, 2);

        // Up at the top bound
        idle_inputs(); clr = 1;
        cyc();
        chk("clr_count", count_w, 0);
        clr = 0; load_en = 1; load_val = 98;
        cyc();
        chk("load98", count_w, 98);
        chk("load_mode", mode_w, 3);
        load_en = 0; run = 1; dir_up = 1;
        cyc();
        chk("resume_up", mode_w, 2);
        tick_en = 1;
        cyc();
        chk("up99_w", count_w, 99);
        chk("up99_tc", tc_w, 0);
        cyc();
        chk("wrap_w_count", count_w, 0);
        chk("wrap_w_tc", tc_w, 1);
        chk("sat_up_count", count_s, 99);
        chk("sat_up_tc", tc_s, 1);
        chk("sat_up_mode", mode_s, 3);
        tick_en = 0;
        cyc();
        chk("wrap_w_tc_off", tc_w, 0);
        chk("wrap_w_mode", mode_w, 2);
        chk("sat_up_tc_off", tc_s, 0);
        chk("sat_up_hold", mode_s, 3);

        // Down at the zero bound, saturate auto-pause and restart
        idle_inputs(); clr = 1;
        cyc();
        clr = 0; load_en = 1; load_val = 1;
        cyc();
        chk("load1", count_s, 1);
        load_en = 0; run = 1; dir_up = 0;
        cyc();
        chk("down_mode", mode_s, 0);
        tick_en = 1;
        cyc();
        chk("down0_s", count_s, 0);
        chk("down0_tc", tc_s, 0);
        cyc();
        chk("sat_dn_count", count_s, 0);
        chk("sat_dn_tc", tc_s, 1);
        chk("sat_dn_mode", mode_s, 3);
        chk("wrap_dn_count", count_w, 99);
        chk("wrap_dn_tc", tc_w, 1);
        chk("wrap_dn_mode", mode_w, 0);
        tick_en = 0;
        cyc();
        chk("sat_dn_tc_off", tc_s, 0);
        chk("sat_lock_hold", mode_s, 3);
        run = 0;
        cyc();
        chk("sat_run_low", mode_s, 3);
        run = 1;
        cyc();
        chk("sat_restart_mode", mode_s, 0);
        chk("sat_restart_run", running_s, 1);
        chk("wrap_dn_hold", count_w, 99);

        // Load clamp and add past the bound
        idle_inputs(); clr = 1;
        cyc();
        clr = 0; load_en = 1; load_val = 120;
        cyc();
        chk("clamp_w", count_w, 99);
        chk("clamp_s", count_s, 99);
        load_en = 0; add_req = 1;
        cyc();
        chk("add_state", mode_w, 3);
        chk("add_pre_count", count_w, 99);
        add_req = 0;
        cyc();
        chk("add_wrap_count", count_w, 4);
        chk("add_wrap_tc", tc_w, 1);
        chk("add_sat_count", count_s, 99);
        chk("add_sat_tc", tc_s, 1);
        chk("add_after_mode", mode_w, 3);
        cyc();
        chk("add_tc_off", tc_w, 0);

        // Add landing exactly on MAX_VAL: no tc
        load_en = 1; load_val = 94;
        cyc();
        load_en = 0; add_req = 1;
        cyc();
        add_req = 0;
        cyc();
        chk("add_eq_count", count_w, 99);
        chk("add_eq_tc", tc_w, 0);
        chk("add_eq_tc_s", tc_s, 0);

        // Add with a simultaneous tick while running up
        load_en = 1; load_val = 10;
        cyc();
        load_en = 0; run = 1; dir_up = 1;
        cyc();
        chk("run10_mode", mode_w, 2);
        tick_en = 1; add_req = 1;
        cyc();
        chk("tick_add_count", count_w, 11);
        chk("tick_add_mode", mode_w, 3);
        add_req = 0;
        cyc();
        chk("add16_count", count_w, 16);
        chk("add16_tc", tc_w, 0);
        chk("add16_mode", mode_w, 2);

        // Run to 37, then clr wins over add_req
        for (int i = 0; i < 21; i++) cyc();
        chk("at37", count_w, 37);
        tick_en = 0; clr = 1; add_req = 1;
        cyc();
        chk("clr_add_count", count_w, 0);
        chk("clr_add_mode", mode_w, 1);
        chk("clr_add_running", running_w, 0);
        chk("clr_add_tc", tc_w, 0);

        // Asynchronous reset mid-count
        idle_inputs(); run = 1; dir_up = 1; tick_en = 1;
        cyc(); cyc(); cyc();
        chk("pre_rst_count", count_w, 2);
        #2 rstn = 0;
        #1;
        chk("arst_count", count_w, 0);
        chk("arst_mode", mode_w, 1);
        chk("arst_running", running_w, 0);
        chk("arst_tc", tc_w, 0);
        #3 rstn = 1;
        cyc();
        chk("post_rst_mode", mode_w, 2);
        chk("post_rst_count", count_w, 0);
        cyc();
        chk("post_rst_tick", count_w, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
